// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared types, constants and burst legality check for axi_mem_slave
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  localparam int BOUNDARY_4K   = 4096;
  localparam int BOUNDARY_BITS = $clog2(BOUNDARY_4K);

  // A burst is illegal if its beat size exceeds the bus, any byte leaves the
  // starting 4 KB page, or its last beat lands beyond the storage.
  function automatic logic burst_err(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [31:0] depth);
    logic [31:0] span;
    logic [31:0] last_byte;
    logic [31:0] last_beat;
    if (size > 3'd2) return 1'b1;
    span      = ({24'd0, len} + 32'd1) << size;
    last_byte = addr + span - 32'd1;
    last_beat = addr + ({24'd0, len} << size);
    return ((addr >> BOUNDARY_BITS) != (last_byte >> BOUNDARY_BITS)) ||
           ((last_beat >> 2) >= depth);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// rtl/axi_mem_array.sv - one-write, one-synchronous-read RAM, read-first on collision
module axi_mem_array #(
  parameter int DEPTH     = 1024,
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only moves when re is set, so a stalled read beat stays put.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI INCR-burst memory slave with independent read and write FSMs
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic [ADDR_WIDTH-1:0] w_addr, r_addr, r_next_addr;
  logic [7:0]            w_len, w_cnt, r_len, r_cnt;
  logic [2:0]            w_size, r_size;
  logic                  w_berr, w_lerr, r_err;
  logic                  aw_hs, w_hs, w_last_beat, ar_hs, r_hs, r_last_beat;

  logic                  mem_we, mem_re;
  logic [IDX_W-1:0]      mem_waddr, mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign ar_hs       = ARVALID && ARREADY;
  assign r_hs        = RVALID && RREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);
  assign r_next_addr = r_addr + (ADDR_WIDTH'(1) << r_size);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_berr  <= 1'b0;
      w_lerr  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_addr <= AWADDR;
        w_len  <= AWLEN;
        w_size <= AWSIZE;
        w_cnt  <= '0;
        w_berr <= burst_err(32'(AWADDR), AWLEN, AWSIZE, 32'(MEM_DEPTH));
        w_lerr <= 1'b0;
      end else if (w_hs) begin
        w_addr <= w_addr + (ADDR_WIDTH'(1) << w_size);
        w_cnt  <= w_cnt + 8'd1;
        // Our own beat count ends the burst; a misplaced WLAST only taints the response.
        w_lerr <= w_lerr | (WLAST != w_last_beat);
      end
    end
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = !ARESET;
        if (AWVALID && !ARESET) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign BRESP = (w_state == W_RESP && (w_berr || w_lerr)) ? SLVERR : OKAY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_addr <= ARADDR;
        r_len  <= ARLEN;
        r_size <= ARSIZE;
        r_cnt  <= '0;
        r_err  <= burst_err(32'(ARADDR), ARLEN, ARSIZE, 32'(MEM_DEPTH));
      end else if (r_hs) begin
        r_addr <= r_next_addr;
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = !ARESET;
        if (ARVALID && !ARESET) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Fetch the first beat on the AR handshake and each following beat on the
  // R handshake, so the RAM output is always the beat currently presented.
  assign mem_re    = ar_hs || (r_hs && !r_last_beat);
  assign mem_raddr = ar_hs ? IDX_W'(ARADDR >> 2) : IDX_W'(r_next_addr >> 2);
  assign mem_we    = w_hs && !w_berr && !ARESET;
  assign mem_waddr = IDX_W'(w_addr >> 2);

  assign RDATA = (r_state == R_DATA && !r_err) ? mem_rdata : '0;
  assign RRESP = (r_state == R_DATA && r_err) ? SLVERR : OKAY;
  assign RLAST = (r_state == R_DATA) && r_last_beat;

  axi_mem_array #(
    .DEPTH    (MEM_DEPTH),
    .WIDTH    (DATA_WIDTH),
    .ADDR_BITS(IDX_W)
  ) u_mem (
    .clk  (ACLK),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(WDATA),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed self-checking bench for axi_mem_slave
module tb_axi_mem_slave;

  logic        ACLK, ARESET;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_cycles;
  logic [1:0]  resp;

  axi_mem_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                          input logic [31:0] base, input int wlast_at, input int bdelay,
                          output logic [1:0] bresp);
    int t;
    @(negedge ACLK);
    AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
    if (!AWREADY) check("aw_timeout", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WDATA = base + 32'(i); WLAST = (i == wlast_at); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
      if (!WREADY) check("w_timeout", 32'(WREADY), 32'd1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    t = 0;
    while (!BVALID && t < 100) begin @(negedge ACLK); t++; end
    if (!BVALID) check("b_timeout", 32'(BVALID), 32'd1);
    bresp = BRESP;
    for (int d = 0; d < bdelay; d++) begin
      @(negedge ACLK);
      check("b_hold", {29'd0, BVALID, BRESP}, {29'd0, 1'b1, bresp});
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input int len, input bit toggle);
    int t, beat, cyc;
    bit held;
    logic [31:0] held_data;
    @(negedge ACLK);
    ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'd2; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
    if (!ARREADY) check("ar_timeout", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("r_first_valid", 32'(RVALID), 32'd1);
    beat = 0; cyc = 0; held = 0; held_data = '0;
    while (beat <= len && cyc < 2000) begin
      RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      if (held && RVALID) check("r_hold", RDATA, held_data);
      if (RVALID && RREADY) begin
        rd_data[beat] = RDATA; rd_resp[beat] = RRESP; rd_last[beat] = RLAST;
        beat++; held = 0;
      end else if (RVALID) begin
        held = 1; held_data = RDATA;
      end
      @(negedge ACLK);
      cyc++;
    end
    RREADY = 1'b0;
    if (beat <= len) check("r_timeout", 32'(beat), 32'(len + 1));
    rd_cycles = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlast;
    ARESET = 1'b1; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    check("reset_ctrl", {22'd0, AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP}, 32'd0);
    check("reset_rdata", RDATA, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_reset_ready", {30'd0, AWREADY, ARREADY}, 32'd3);

    // single beat
    do_write(16'h0010, 0, 3'd2, 32'hDEADBEEF, 0, 0, resp);
    check("single_bresp", 32'(resp), 32'd0);
    do_read(16'h0010, 0, 0);
    check("single_rdata", rd_data[0], 32'hDEADBEEF);
    check("single_rlast_rresp", {29'd0, rd_last[0], rd_resp[0]}, {29'd0, 1'b1, 2'b00});

    // four-beat burst, full throughput
    do_write(16'h0100, 3, 3'd2, 32'd1, 3, 0, resp);
    check("burst_bresp", 32'(resp), 32'd0);
    do_read(16'h0100, 3, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_rdata%0d", i), rd_data[i], 32'(i + 1));
      check($sformatf("burst_rlast%0d", i), 32'(rd_last[i]), 32'(i == 3));
      check($sformatf("burst_rresp%0d", i), 32'(rd_resp[i]), 32'd0);
    end
    check("burst_cycles", 32'(rd_cycles), 32'd4);

    // error bursts leave storage alone
    do_write(16'h0FF8, 1, 3'd2, 32'hA0, 1, 0, resp);
    check("pre_4k_bresp", 32'(resp), 32'd0);
    do_write(16'h0FF8, 3, 3'd2, 32'h55, 3, 0, resp);
    check("cross_4k_bresp", 32'(resp), 32'd2);
    do_read(16'h0FF8, 1, 0);
    check("cross_4k_kept0", rd_data[0], 32'hA0);
    check("cross_4k_kept1", rd_data[1], 32'hA1);
    do_read(16'h0FF8, 3, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("cross_4k_rd%0d", i), {rd_data[i][29:0], rd_resp[i]}, 32'd2);
    do_write(16'h1000, 0, 3'd2, 32'h77, 0, 0, resp);
    check("oob_bresp", 32'(resp), 32'd2);
    do_read(16'h1000, 0, 0);
    check("oob_rdata", rd_data[0], 32'd0);
    check("oob_rresp_rlast", {29'd0, rd_last[0], rd_resp[0]}, {29'd0, 1'b1, 2'b10});
    do_write(16'h0500, 0, 3'd3, 32'h99, 0, 0, resp);
    check("size_bresp", 32'(resp), 32'd2);

    // misplaced WLAST
    do_write(16'h0200, 1, 3'd2, 32'h10, 0, 0, resp);
    check("early_wlast_bresp", 32'(resp), 32'd2);
    do_write(16'h0200, 1, 3'd2, 32'h10, -1, 0, resp);
    check("missing_wlast_bresp", 32'(resp), 32'd2);

    // B backpressure and R backpressure
    do_write(16'h0020, 0, 3'd2, 32'h11111111, 0, 5, resp);
    check("bp_bresp", 32'(resp), 32'd0);
    do_read(16'h0100, 3, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("toggle_rdata%0d", i), rd_data[i], 32'(i + 1));

    // same-word write and read in one cycle: read sees old data
    @(negedge ACLK);
    check("cc_awready", 32'(AWREADY), 32'd1);
    AWADDR = 16'h0020; AWLEN = 8'd0; AWSIZE = 3'd2; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA = 32'h22222222; WLAST = 1'b1; WVALID = 1'b1;
    ARADDR = 16'h0020; ARLEN = 8'd0; ARSIZE = 3'd2; ARVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    check("cc_rvalid_bvalid", {30'd0, RVALID, BVALID}, 32'd3);
    check("cc_old_data", RDATA, 32'h11111111);
    RREADY = 1'b1; BREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0; BREADY = 1'b0;
    do_read(16'h0020, 0, 0);
    check("cc_new_data", rd_data[0], 32'h22222222);

    // reset during beat 2 of an 8-beat write
    @(negedge ACLK);
    AWADDR = 16'h0300; AWLEN = 8'd7; AWSIZE = 3'd2; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hCAFE0000;
    @(negedge ACLK);
    WDATA = 32'hCAFE0001;
    @(negedge ACLK);
    WDATA = 32'hCAFE0002; ARESET = 1'b1;
    @(negedge ACLK);
    check("midrst_ctrl", {22'd0, AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP}, 32'd0);
    check("midrst_rdata", RDATA, 32'd0);
    ARESET = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check("midrst_awready_nob", {30'd0, AWREADY, BVALID}, 32'd2);
    do_read(16'h0100, 0, 0);
    check("midrst_kept", rd_data[0], 32'd1);

    // 256-beat burst
    do_write(16'h0400, 255, 3'd2, 32'h1000, 255, 0, resp);
    check("long_bresp", 32'(resp), 32'd0);
    do_read(16'h0400, 255, 0);
    nlast = 0;
    for (int i = 0; i < 256; i++) nlast += int'(rd_last[i]);
    check("long_first", rd_data[0], 32'h1000);
    check("long_last", rd_data[255], 32'h10FF);
    check("long_rlast", {31'd0, rd_last[255]}, 32'd1);
    check("long_nlast", 32'(nlast), 32'd1);
    check("long_cycles", 32'(rd_cycles), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
